// File: rtl/mkio_pkg.sv
// Shared types and constants for the MKIO redundant-bus channel manager.
package mkio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    TX   = 2'd2,
    TAIL = 2'd3
  } state_t;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  localparam int ACT_MIN_DEF  = 8;
  localparam int IDLE_CYC_DEF = 64;
  localparam int TAIL_CYC_DEF = 5;
  localparam int ERR_MAX_DEF  = 3;

endpackage

// File: rtl/mkio_channel_ctrl_if.sv
// Line-side, transmitter/receiver-side and status signals of the channel manager.
interface mkio_channel_ctrl_if;
  logic DI1A, DI0A, DI1B, DI0B;
  logic DI1, DI0;
  logic DO1, DO0;
  logic DO1A, DO0A, DO1B, DO0B;
  logic tx_busy, rx_done, parity_error, clear_fault;
  logic RX_STROB_A, RX_STROB_B, TX_INHIBIT_A, TX_INHIBIT_B;
  logic active_ch, fault_a, fault_b;

  modport slave (
    input  DI1A, DI0A, DI1B, DI0B, DO1, DO0, tx_busy, rx_done, parity_error, clear_fault,
    output DI1, DI0, DO1A, DO0A, DO1B, DO0B, RX_STROB_A, RX_STROB_B,
    output TX_INHIBIT_A, TX_INHIBIT_B, active_ch, fault_a, fault_b
  );

  modport master (
    output DI1A, DI0A, DI1B, DI0B, DO1, DO0, tx_busy, rx_done, parity_error, clear_fault,
    input  DI1, DI0, DO1A, DO0A, DO1B, DO0B, RX_STROB_A, RX_STROB_B,
    input  TX_INHIBIT_A, TX_INHIBIT_B, active_ch, fault_a, fault_b
  );
endinterface

// File: rtl/mkio_act_filter.sv
// Per-channel input path: 2-flop synchroniser, ACT_MIN-stage delay line and
// an activity detector that pulses once when a run of line activity reaches ACT_MIN.
module mkio_act_filter #(
  parameter int ACT_MIN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic din1,
  input  logic din0,
  output logic dly1,
  output logic dly0,
  output logic line_hi,
  output logic act
);

  localparam int CW = $clog2(ACT_MIN + 1);

  logic [1:0]    sync1_r;
  logic [1:0]    sync2_r;
  logic [1:0]    dly_r [ACT_MIN];
  logic [CW-1:0] run_r;

  // synchroniser, delay line and run-length counter
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
      for (int i = 0; i < ACT_MIN; i++) dly_r[i] <= 2'b00;
      run_r   <= CW'(0);
    end else begin
      sync1_r  <= {din1, din0};
      sync2_r  <= sync1_r;
      dly_r[0] <= sync2_r;
      for (int i = 1; i < ACT_MIN; i++) dly_r[i] <= dly_r[i-1];
      if (!(|sync2_r)) begin
        run_r <= CW'(0);
      end else if (run_r != CW'(ACT_MIN)) begin
        run_r <= run_r + CW'(1);
      end else begin
        run_r <= run_r;
      end
    end
  end

  // Single pulse on the cycle the run reaches ACT_MIN, so a continuing word
  // cannot re-supersede the lock every cycle.
  assign act     = (|sync2_r) && (run_r == CW'(ACT_MIN - 1));
  assign line_hi = |sync2_r;
  assign dly1    = dly_r[ACT_MIN-1][1];
  assign dly0    = dly_r[ACT_MIN-1][0];

endmodule

// File: rtl/mkio_channel_ctrl.sv
// Redundant A/B bus channel manager: locks the receiver onto one channel,
// routes transmitter output to the locked channel and retires noisy channels.
module mkio_channel_ctrl
  import mkio_pkg::*;
#(
  parameter int ACT_MIN  = ACT_MIN_DEF,
  parameter int IDLE_CYC = IDLE_CYC_DEF,
  parameter int TAIL_CYC = TAIL_CYC_DEF,
  parameter int ERR_MAX  = ERR_MAX_DEF
) (
  input logic          clk,
  input logic          reset,
  mkio_channel_ctrl_if.slave bus
);

  localparam int IDLE_W = $clog2(IDLE_CYC + 1);
  localparam int TAIL_W = $clog2(TAIL_CYC + 1);
  localparam int ERR_W  = $clog2(ERR_MAX + 1);

  logic dly1_a_s, dly0_a_s, hi_a_s, act_a_s;
  logic dly1_b_s, dly0_b_s, hi_b_s, act_b_s;

  state_t state_r, state_nxt_s;
  logic   active_r, active_nxt_s, idle_clr_s;
  logic [IDLE_W-1:0] idle_cnt_r;
  logic [TAIL_W-1:0] tail_cnt_r;
  logic [ERR_W-1:0]  err_a_r, err_b_r;
  logic fault_a_r, fault_b_r;
  logic di1_r, di0_r, do1a_r, do0a_r, do1b_r, do0b_r;
  logic strob_a_r, strob_b_r, inh_a_r, inh_b_r;

  mkio_act_filter #(.ACT_MIN(ACT_MIN)) u_filt_a (
    .clk(clk), .reset(reset), .din1(bus.DI1A), .din0(bus.DI0A),
    .dly1(dly1_a_s), .dly0(dly0_a_s), .line_hi(hi_a_s), .act(act_a_s)
  );

  mkio_act_filter #(.ACT_MIN(ACT_MIN)) u_filt_b (
    .clk(clk), .reset(reset), .din1(bus.DI1B), .din0(bus.DI0B),
    .dly1(dly1_b_s), .dly0(dly0_b_s), .line_hi(hi_b_s), .act(act_b_s)
  );

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_W'(ERR_MAX)) ? v : v + ERR_W'(1);
  endfunction

  logic ok_a_s, ok_b_s, other_ok_s, locked_fault_s, locked_hi_s, both_fault_s, txing_s;
  assign ok_a_s         = act_a_s & ~fault_a_r;
  assign ok_b_s         = act_b_s & ~fault_b_r;
  assign other_ok_s     = (active_r == CH_A) ? ok_b_s : ok_a_s;
  assign locked_fault_s = (active_r == CH_A) ? fault_a_r : fault_b_r;
  assign locked_hi_s    = (active_r == CH_A) ? hi_a_s : hi_b_s;
  assign both_fault_s   = fault_a_r & fault_b_r;
  assign txing_s        = (state_r == TX) || (state_r == TAIL);

  // next-state and lock selection
  always_comb begin
    state_nxt_s  = state_r;
    active_nxt_s = active_r;
    idle_clr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (both_fault_s) begin
          state_nxt_s = IDLE;
        end else if (bus.tx_busy) begin
          state_nxt_s = TX;
        end else if (ok_a_s) begin
          state_nxt_s  = RX;
          active_nxt_s = CH_A;
          idle_clr_s   = 1'b1;
        end else if (ok_b_s) begin
          state_nxt_s  = RX;
          active_nxt_s = CH_B;
          idle_clr_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RX: begin
        if (bus.tx_busy) begin
          state_nxt_s = TX;
        end else if (other_ok_s) begin
          active_nxt_s = ~active_r;
          idle_clr_s   = 1'b1;
        end else if (locked_fault_s || (idle_cnt_r == IDLE_W'(IDLE_CYC))) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RX;
        end
      end
      TX: begin
        if (bus.tx_busy) state_nxt_s = TX;
        else             state_nxt_s = TAIL;
      end
      TAIL: begin
        if (bus.tx_busy) begin
          state_nxt_s = TX;
        end else if (tail_cnt_r == TAIL_W'(TAIL_CYC - 1)) begin
          if (locked_fault_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = RX;
            idle_clr_s  = 1'b1;
          end
        end else begin
          state_nxt_s = TAIL;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // state register, idle and tail counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      active_r   <= CH_A;
      idle_cnt_r <= IDLE_W'(0);
      tail_cnt_r <= TAIL_W'(0);
    end else begin
      state_r  <= state_nxt_s;
      active_r <= active_nxt_s;
      if (idle_clr_s || (state_r != RX) || locked_hi_s) idle_cnt_r <= IDLE_W'(0);
      else if (idle_cnt_r != IDLE_W'(IDLE_CYC))         idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
      else                                              idle_cnt_r <= idle_cnt_r;
      tail_cnt_r <= (state_r == TAIL) ? tail_cnt_r + TAIL_W'(1) : TAIL_W'(0);
    end
  end

  // parity-error counting and channel retirement; clear_fault wins over a same-cycle error
  always_ff @(posedge clk) begin
    if (reset || bus.clear_fault) begin
      err_a_r   <= ERR_W'(0);
      err_b_r   <= ERR_W'(0);
      fault_a_r <= 1'b0;
      fault_b_r <= 1'b0;
    end else begin
      if (bus.rx_done && (state_r == RX) && (active_r == CH_A))
        err_a_r <= bus.parity_error ? sat_inc(err_a_r) : ERR_W'(0);
      if (bus.rx_done && (state_r == RX) && (active_r == CH_B))
        err_b_r <= bus.parity_error ? sat_inc(err_b_r) : ERR_W'(0);
      if (err_a_r == ERR_W'(ERR_MAX)) fault_a_r <= 1'b1;
      if (err_b_r == ERR_W'(ERR_MAX)) fault_b_r <= 1'b1;
    end
  end

  // registered line/receiver outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      {di1_r, di0_r}                  <= 2'b00;
      {do1a_r, do0a_r, do1b_r, do0b_r} <= 4'b0000;
      {strob_a_r, strob_b_r}          <= 2'b11;
      {inh_a_r, inh_b_r}              <= 2'b11;
    end else begin
      di1_r     <= (state_r == RX) ? ((active_r == CH_B) ? dly1_b_s : dly1_a_s) : 1'b0;
      di0_r     <= (state_r == RX) ? ((active_r == CH_B) ? dly0_b_s : dly0_a_s) : 1'b0;
      do1a_r    <= (txing_s && (active_r == CH_A)) ? bus.DO1 : 1'b0;
      do0a_r    <= (txing_s && (active_r == CH_A)) ? bus.DO0 : 1'b0;
      do1b_r    <= (txing_s && (active_r == CH_B)) ? bus.DO1 : 1'b0;
      do0b_r    <= (txing_s && (active_r == CH_B)) ? bus.DO0 : 1'b0;
      inh_a_r   <= ~(txing_s && (active_r == CH_A));
      inh_b_r   <= ~(txing_s && (active_r == CH_B));
      strob_a_r <= ~txing_s & ~fault_a_r;
      strob_b_r <= ~txing_s & ~fault_b_r;
    end
  end

  assign bus.DI1          = di1_r;
  assign bus.DI0          = di0_r;
  assign bus.DO1A         = do1a_r;
  assign bus.DO0A         = do0a_r;
  assign bus.DO1B         = do1b_r;
  assign bus.DO0B         = do0b_r;
  assign bus.RX_STROB_A   = strob_a_r;
  assign bus.RX_STROB_B   = strob_b_r;
  assign bus.TX_INHIBIT_A = inh_a_r;
  assign bus.TX_INHIBIT_B = inh_b_r;
  assign bus.active_ch    = active_r;
  assign bus.fault_a      = fault_a_r;
  assign bus.fault_b      = fault_b_r;

endmodule

// File: tb/tb_mkio_channel_ctrl.sv
// Self-checking bench for mkio_channel_ctrl: scoreboarded DI/DO streams plus
// lock, supersede, transmit, fault and reset scenarios.
module tb_mkio_channel_ctrl;
  localparam int DLY = 11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mkio_channel_ctrl_if bus ();
  mkio_channel_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [1:0] di_q[$];
  logic [1:0] do_q[$];

  task automatic set_pins(input logic [1:0] a, input logic [1:0] b);
    bus.DI1A = a[1]; bus.DI0A = a[0];
    bus.DI1B = b[1]; bus.DI0B = b[0];
  endtask

  function automatic logic [1:0] rnd_sym();
    logic bit_v;
    bit_v = 1'($urandom_range(0, 1));
    return {bit_v, ~bit_v};
  endfunction

  task automatic prefill();
    di_q.delete();
    for (int i = 0; i < DLY; i++) di_q.push_back(2'b00);
  endtask

  task automatic idle(input int n);
    set_pins(2'b00, 2'b00);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_done(input logic perr, input logic clr);
    @(negedge clk);
    bus.rx_done = 1'b1; bus.parity_error = perr; bus.clear_fault = clr;
    @(negedge clk);
    bus.rx_done = 1'b0; bus.parity_error = 1'b0; bus.clear_fault = 1'b0;
  endtask

  task automatic lock_word(input logic on_b);
    for (int i = 0; i < 33; i++) begin
      logic [1:0] w;
      @(negedge clk);
      w = (i < 30) ? rnd_sym() : 2'b00;
      if (on_b) set_pins(2'b00, w);
      else      set_pins(w, 2'b00);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.DO1 = 1'b0; bus.DO0 = 1'b0; bus.tx_busy = 1'b0;
    bus.rx_done = 1'b0; bus.parity_error = 1'b0; bus.clear_fault = 1'b0;
    set_pins(2'b00, 2'b00);
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.DI1, bus.DI0, bus.DO1A, bus.DO0A, bus.DO1B, bus.DO0B} !== 6'b000000) begin
      errors++; $display("FAIL reset_data got %b%b%b%b%b%b expected 000000", bus.DI1, bus.DI0, bus.DO1A, bus.DO0A, bus.DO1B, bus.DO0B);
    end
    checks++;
    if ({bus.RX_STROB_A, bus.RX_STROB_B, bus.TX_INHIBIT_A, bus.TX_INHIBIT_B} !== 4'b1111) begin
      errors++; $display("FAIL reset_strobes got %b%b%b%b expected 1111", bus.RX_STROB_A, bus.RX_STROB_B, bus.TX_INHIBIT_A, bus.TX_INHIBIT_B);
    end
    checks++;
    if ({bus.active_ch, bus.fault_a, bus.fault_b} !== 3'b000) begin
      errors++; $display("FAIL reset_status got %b%b%b expected 000", bus.active_ch, bus.fault_a, bus.fault_b);
    end
    reset = 1'b0;
    idle(15);
  endtask

  task automatic test_word_a();
    int strob_bad = 0;
    prefill();
    for (int i = 0; i < 130; i++) begin
      logic [1:0] a, exp_v;
      @(negedge clk);
      exp_v = di_q.pop_front();
      checks++;
      if ({bus.DI1, bus.DI0} !== exp_v) begin
        errors++; $display("FAIL word_a_di cycle %0d got %b%b expected %b", i, bus.DI1, bus.DI0, exp_v);
      end
      if ({bus.RX_STROB_A, bus.RX_STROB_B} !== 2'b11) strob_bad++;
      a = (i < 30) ? rnd_sym() : 2'b00;
      set_pins(a, 2'b00);
      di_q.push_back(a);
    end
    checks++;
    if (strob_bad != 0) begin errors++; $display("FAIL word_a_strob low cycles %0d expected 0", strob_bad); end
    checks++;
    if (bus.active_ch !== 1'b0) begin errors++; $display("FAIL word_a_active got %b expected 0", bus.active_ch); end
  endtask

  task automatic test_supersede();
    prefill();
    for (int i = 0; i < 165; i++) begin
      logic [1:0] a, b, exp_v;
      @(negedge clk);
      exp_v = di_q.pop_front();
      checks++;
      if ({bus.DI1, bus.DI0} !== exp_v) begin
        errors++; $display("FAIL supersede_di cycle %0d got %b%b expected %b", i, bus.DI1, bus.DI0, exp_v);
      end
      if (i == 44 || i == 45) begin
        checks++;
        if (bus.active_ch !== ((i == 45) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL supersede_active cycle %0d got %b expected %b", i, bus.active_ch, (i == 45));
        end
      end
      a = (i < 30) ? rnd_sym() : 2'b00;
      b = (i >= 35 && i < 65) ? rnd_sym() : 2'b00;
      set_pins(a, b);
      di_q.push_back((i >= 35) ? b : a);
    end
  endtask

  task automatic test_same_cycle();
    prefill();
    for (int i = 0; i < 130; i++) begin
      logic [1:0] a, b, exp_v;
      @(negedge clk);
      exp_v = di_q.pop_front();
      checks++;
      if ({bus.DI1, bus.DI0} !== exp_v) begin
        errors++; $display("FAIL same_cycle_di cycle %0d got %b%b expected %b", i, bus.DI1, bus.DI0, exp_v);
      end
      if (i == 9 || i == 10 || i == 129) begin
        checks++;
        if (bus.active_ch !== ((i == 9) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL same_cycle_active cycle %0d got %b expected %b", i, bus.active_ch, (i == 9));
        end
      end
      a = (i < 30) ? rnd_sym() : 2'b00;
      b = (i < 30) ? rnd_sym() : 2'b00;
      set_pins(a, b);
      di_q.push_back(a);
    end
  endtask

  task automatic test_tx();
    int inh_a_low = 0, inh_b_low = 0, strob_low = 0;
    lock_word(1'b0);
    do_q.delete();
    do_q.push_back(2'b00);
    for (int j = 0; j < 360; j++) begin
      logic [1:0] d, exp_v;
      @(negedge clk);
      exp_v = do_q.pop_front();
      checks++;
      if ({bus.DO1A, bus.DO0A} !== exp_v) begin
        errors++; $display("FAIL tx_doa cycle %0d got %b%b expected %b", j, bus.DO1A, bus.DO0A, exp_v);
      end
      checks++;
      if ({bus.DO1B, bus.DO0B} !== 2'b00) begin
        errors++; $display("FAIL tx_dob cycle %0d got %b%b expected 00", j, bus.DO1B, bus.DO0B);
      end
      if (!bus.TX_INHIBIT_A) inh_a_low++;
      if (!bus.TX_INHIBIT_B) inh_b_low++;
      if (!bus.RX_STROB_A && !bus.RX_STROB_B) strob_low++;
      d = 2'($urandom_range(0, 3));
      bus.DO1 = d[1]; bus.DO0 = d[0];
      bus.tx_busy = (j < 320);
      set_pins(2'b00, (j >= 50 && j < 100) ? rnd_sym() : 2'b00);
      do_q.push_back((j + 1 >= 2 && j + 1 <= 326) ? d : 2'b00);
    end
    bus.DO1 = 1'b0; bus.DO0 = 1'b0;
    checks++;
    if (inh_a_low != 325) begin errors++; $display("FAIL tx_inhibit_a low cycles %0d expected 325", inh_a_low); end
    checks++;
    if (inh_b_low != 0) begin errors++; $display("FAIL tx_inhibit_b low cycles %0d expected 0", inh_b_low); end
    checks++;
    if (strob_low != 325) begin errors++; $display("FAIL tx_strob low cycles %0d expected 325", strob_low); end
    checks++;
    if (bus.active_ch !== 1'b0) begin errors++; $display("FAIL tx_active got %b expected 0", bus.active_ch); end
    idle(80);
  endtask

  task automatic test_fault();
    lock_word(1'b1);
    checks++;
    if (bus.active_ch !== 1'b1) begin errors++; $display("FAIL fault_lock_b got %b expected 1", bus.active_ch); end
    pulse_done(1'b1, 1'b0);
    pulse_done(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.fault_b !== 1'b0) begin errors++; $display("FAIL fault_b_early got %b expected 0", bus.fault_b); end
    pulse_done(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.fault_a, bus.fault_b} !== 2'b01) begin errors++; $display("FAIL fault_set got %b%b expected 01", bus.fault_a, bus.fault_b); end
    checks++;
    if ({bus.RX_STROB_A, bus.RX_STROB_B} !== 2'b10) begin
      errors++; $display("FAIL fault_strob got %b%b expected 10", bus.RX_STROB_A, bus.RX_STROB_B);
    end
    idle(15);
    prefill();
    for (int i = 0; i < 50; i++) begin
      logic [1:0] exp_v;
      @(negedge clk);
      exp_v = di_q.pop_front();
      checks++;
      if ({bus.DI1, bus.DI0} !== exp_v) begin
        errors++; $display("FAIL fault_ignore_di cycle %0d got %b%b expected %b", i, bus.DI1, bus.DI0, exp_v);
      end
      set_pins(2'b00, (i < 30) ? rnd_sym() : 2'b00);
      di_q.push_back(2'b00);
    end
    pulse_done(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.fault_b, bus.RX_STROB_B} !== 2'b01) begin
      errors++; $display("FAIL fault_clear got fault_b=%b strob_b=%b expected 0 1", bus.fault_b, bus.RX_STROB_B);
    end
    lock_word(1'b1);
    pulse_done(1'b1, 1'b0);
    pulse_done(1'b1, 1'b0);
    pulse_done(1'b1, 1'b1);
    pulse_done(1'b1, 1'b0);
    pulse_done(1'b1, 1'b0);
    pulse_done(1'b0, 1'b0);
    pulse_done(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.fault_b !== 1'b0) begin errors++; $display("FAIL fault_clear_priority got %b expected 0", bus.fault_b); end
    idle(100);
  endtask

  task automatic test_reset_tx();
    int inh_low = 0;
    lock_word(1'b1);
    bus.tx_busy = 1'b1; bus.DO1 = 1'b1; bus.DO0 = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if ({bus.DO1B, bus.DO0B, bus.TX_INHIBIT_B} !== 3'b110) begin
      errors++; $display("FAIL reset_tx_pre got %b%b%b expected 110", bus.DO1B, bus.DO0B, bus.TX_INHIBIT_B);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.DO1A, bus.DO0A, bus.DO1B, bus.DO0B, bus.DI1, bus.DI0} !== 6'b000000) begin
      errors++; $display("FAIL reset_tx_do got %b%b%b%b expected 0000", bus.DO1A, bus.DO0A, bus.DO1B, bus.DO0B);
    end
    checks++;
    if ({bus.TX_INHIBIT_A, bus.TX_INHIBIT_B, bus.RX_STROB_A, bus.RX_STROB_B, bus.active_ch} !== 5'b11110) begin
      errors++; $display("FAIL reset_tx_ctrl got %b%b%b%b%b expected 11110", bus.TX_INHIBIT_A, bus.TX_INHIBIT_B, bus.RX_STROB_A, bus.RX_STROB_B, bus.active_ch);
    end
    reset = 1'b0; bus.tx_busy = 1'b0; bus.DO1 = 1'b0; bus.DO0 = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.TX_INHIBIT_A || !bus.TX_INHIBIT_B) inh_low++;
    end
    checks++;
    if (inh_low != 0) begin errors++; $display("FAIL reset_tx_idle inhibit low cycles %0d expected 0", inh_low); end
  endtask

  initial begin
    test_reset();
    test_word_a();
    test_supersede();
    test_same_cycle();
    test_tx();
    test_fault();
    test_reset_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
